// File: rtl/keypad_display_scan_if.sv
// Keypad entry and display drive bundle between keypad/calculator logic and the scan driver.
// The master drives the key strobe, clear and blanking mode; the slave returns digit enables, segments and ovf.
interface keypad_display_scan_if #(
  parameter int DIGITS = 4
);
  logic [3:0]        tecla;
  logic              tecla_valid;
  logic              clear;
  logic              lzb;
  logic [DIGITS-1:0] an;
  logic [6:0]        CSseg;
  logic              ovf;

  modport master (
    output tecla, tecla_valid, clear, lzb,
    input  an, CSseg, ovf
  );

  modport slave (
    input  tecla, tecla_valid, clear, lzb,
    output an, CSseg, ovf
  );
endinterface

// File: rtl/keypad_display_scan.sv
// Time-multiplexed DIGITS-position 7-segment driver with a right-shifting key buffer.
// an/CSseg are registered one cycle behind the scan index and buffer; ovf is a sticky register.
module keypad_display_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keypad_display_scan_if.slave  kd
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [3:0]       BLANK    = 4'hF;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [3:0]        dig_q [DIGITS];
  logic [3:0]        dig_d [DIGITS];
  logic              ovf_q, ovf_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] blank_mask;
  logic              higher_empty;
  logic [3:0]        shown_code;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b1101100;
      4'hB:    seg = 7'b1111110;
      4'hC:    seg = 7'b1001000;
      4'hD:    seg = 7'b1011011;
      4'hE:    seg = 7'b1110110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Key entry: clear takes priority over a coincident key strobe.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) dig_d[i] = dig_q[i];
    ovf_d = ovf_q;
    if (kd.clear) begin
      for (int i = 0; i < DIGITS; i++) dig_d[i] = BLANK;
      ovf_d = 1'b0;
    end else if (kd.tecla_valid) begin
      for (int i = 1; i < DIGITS; i++) dig_d[i] = dig_q[i-1];
      dig_d[0] = kd.tecla;
      if (dig_q[DIGITS-1] != BLANK) ovf_d = 1'b1;
    end
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Walk from the most significant digit down; a zero is blanked while nothing above it is significant.
  always_comb begin
    blank_mask   = '0;
    higher_empty = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (kd.lzb && higher_empty && dig_q[i] == 4'h0) blank_mask[i] = 1'b1;
      higher_empty = higher_empty && (dig_q[i] == 4'h0 || dig_q[i] == BLANK);
    end
  end

  always_comb begin
    shown_code = blank_mask[idx_q] ? BLANK : dig_q[idx_q];
    seg_d      = seg_decode(shown_code);
    an_d       = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= BLANK;
      ovf_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= dig_d[i];
      ovf_q <= ovf_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign kd.an    = an_q;
  assign kd.CSseg = seg_q;
  assign kd.ovf   = ovf_q;

endmodule

// File: tb/tb_keypad_display_scan.sv
// Bench for keypad_display_scan (DIGITS=4, SCAN_DIV=4): reference model plus per-cycle compare and literal scenarios.
module tb_keypad_display_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk;
  logic rst_n;
  logic cmp_en;
  int   n_checks;
  int   n_errors;

  keypad_display_scan_if #(.DIGITS(DIGITS)) kd();

  keypad_display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kd    (kd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16];
  logic [3:0] m_buf [DIGITS];
  int         m_pre;
  int         m_idx;
  logic       m_ovf;
  logic [3:0] e_an;
  logic [6:0] e_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest position holding a real digit (not 0, not blank); -1 if none.
  function automatic int top_significant();
    int top = -1;
    for (int i = 0; i < DIGITS; i++)
      if (m_buf[i] != 4'h0 && m_buf[i] != 4'hF) top = i;
    return top;
  endfunction

  function automatic logic [3:0] shown(input int i, input logic lzb);
    if (lzb && i > 0 && m_buf[i] == 4'h0 && i > top_significant()) return 4'hF;
    return m_buf[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) m_buf[i] = 4'hF;
      m_pre = 0;
      m_idx = 0;
      m_ovf = 1'b0;
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
    end else begin
      e_an  = 4'b1111;
      e_an[m_idx] = 1'b0;
      e_seg = seg_tab[shown(m_idx, kd.lzb)];
      if (kd.clear) begin
        for (int i = 0; i < DIGITS; i++) m_buf[i] = 4'hF;
        m_ovf = 1'b0;
      end else if (kd.tecla_valid) begin
        if (m_buf[DIGITS-1] != 4'hF) m_ovf = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = kd.tecla;
      end
      m_pre = (m_pre + 1) % SCAN_DIV;
      if (m_pre == 0) m_idx = (m_idx + 1) % DIGITS;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model an", 32'(kd.an), 32'(e_an));
      check("model seg", 32'(kd.CSseg), 32'(e_seg));
      check("model ovf", 32'(kd.ovf), 32'(m_ovf));
    end
  end

  task automatic key(input logic [3:0] k);
    kd.tecla       = k;
    kd.tecla_valid = 1'b1;
    @(negedge clk);
    kd.tecla_valid = 1'b0;
  endtask

  task automatic clr();
    kd.clear = 1'b1;
    @(negedge clk);
    kd.clear = 1'b0;
  endtask

  // One full 16-cycle scan: each digit lit for 4 clocks showing the given segments.
  task automatic window(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3);
    int cnt [4];
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (kd.an)
        4'b1110: begin cnt[0]++; check({tag, " d0"}, 32'(kd.CSseg), 32'(e0)); end
        4'b1101: begin cnt[1]++; check({tag, " d1"}, 32'(kd.CSseg), 32'(e1)); end
        4'b1011: begin cnt[2]++; check({tag, " d2"}, 32'(kd.CSseg), 32'(e2)); end
        4'b0111: begin cnt[3]++; check({tag, " d3"}, 32'(kd.CSseg), 32'(e3)); end
        default: check({tag, " an onehot"}, 32'(kd.an), 32'(4'b1110));
      endcase
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s dwell%0d", tag, i), 32'(cnt[i]), 32'd4);
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b1101100; seg_tab[11] = 7'b1111110;
    seg_tab[12] = 7'b1001000; seg_tab[13] = 7'b1011011; seg_tab[14] = 7'b1110110;
    seg_tab[15] = 7'b1111111;
    n_checks = 0;
    n_errors = 0;
    cmp_en   = 1'b0;
    kd.tecla = 4'h0;
    kd.tecla_valid = 1'b0;
    kd.clear = 1'b0;
    kd.lzb   = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    repeat (3) @(negedge clk);
    check("reset an", 32'(kd.an), 32'(4'b1111));
    check("reset seg", 32'(kd.CSseg), 32'(7'b1111111));
    check("reset ovf", 32'(kd.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first an", 32'(kd.an), 32'(4'b1110));
    check("first seg", 32'(kd.CSseg), 32'(7'b1111111));

    key(4'd1); key(4'd2); key(4'd3);
    @(negedge clk);
    window("keys123", 7'b0000110, 7'b0010010, 7'b1001111, 7'b1111111);

    clr();
    kd.lzb = 1'b1;
    key(4'd0); key(4'd0); key(4'd5);
    @(negedge clk);
    window("lzb on", 7'b0100100, 7'b1111111, 7'b1111111, 7'b1111111);
    kd.lzb = 1'b0;
    @(negedge clk);
    window("lzb off", 7'b0100100, 7'b0000001, 7'b0000001, 7'b1111111);

    clr();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    @(negedge clk);
    check("ovf set", 32'(kd.ovf), 32'd1);
    window("overflow", 7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010);
    clr();
    @(negedge clk);
    check("ovf cleared", 32'(kd.ovf), 32'd0);
    window("cleared", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111);

    key(4'd9);
    kd.clear = 1'b1;
    kd.tecla = 4'd7;
    kd.tecla_valid = 1'b1;
    @(negedge clk);
    kd.clear = 1'b0;
    kd.tecla_valid = 1'b0;
    @(negedge clk);
    window("clear wins", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111);

    for (int c = 0; c < 1500; c++) begin
      kd.tecla       = 4'($urandom_range(0, 15));
      kd.tecla_valid = ($urandom_range(0, 3) == 0);
      kd.clear       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) kd.lzb = ~kd.lzb;
      @(negedge clk);
    end
    kd.tecla_valid = 1'b0;
    kd.clear = 1'b0;

    begin
      int waited = 0;
      while (kd.an !== 4'b1011 && waited < 64) begin
        @(negedge clk);
        waited++;
      end
      check("reach digit2", 32'(kd.an), 32'(4'b1011));
    end
    #2 rst_n = 1'b0;
    #1;
    check("async an", 32'(kd.an), 32'(4'b1111));
    check("async seg", 32'(kd.CSseg), 32'(7'b1111111));
    check("async ovf", 32'(kd.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart an", 32'(kd.an), 32'(4'b1110));
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
